// File: rtl/cont_rx_expander.sv
// cont_rx_expander: undoes CONT compression on the receive stream.
// Optional stats via `CONT_RX_STATS_EN (junk_count / cont_count).
//
// Ports:
//   clk, rst (async, active-low), phy_ready (link up)
//   rx_din/rx_is_k   : raw received dword and K flags (bit 0 = primitive)
//   exp_dout/exp_is_k: expanded dword and flags, exp_valid = phy_ready
//   cont_active      : output dword belongs to a CONT run
//   held_prim        : last repeatable primitive latched
//   cont_err         : pulse on orphan CONT or run length overflow
//   junk_count       : saturating count of suppressed junk dwords
//   cont_count       : saturating count of CONT runs entered
module cont_rx_expander #(
    parameter int JUNK_LIMIT = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phy_ready,
    input  logic [31:0]      rx_din,
    input  logic [3:0]       rx_is_k,
    output logic [31:0]      exp_dout,
    output logic [3:0]       exp_is_k,
    output logic             exp_valid,
    output logic             cont_active,
    output logic [31:0]      held_prim,
    output logic             cont_err,
    output logic [CNT_W-1:0] junk_count,
    output logic [CNT_W-1:0] cont_count
);

    localparam logic [31:0] P_ALIGN  = 32'h7B4A_4ABC;
    localparam logic [31:0] P_CONT   = 32'h9999_AA7C;
    localparam logic [31:0] P_SYNC   = 32'hB5B5_957C;
    localparam logic [31:0] P_R_RDY  = 32'h4A4A_957C;
    localparam logic [31:0] P_R_IP   = 32'h5555_B57C;
    localparam logic [31:0] P_R_ERR  = 32'h5656_B57C;
    localparam logic [31:0] P_R_OK   = 32'h3535_B57C;
    localparam logic [31:0] P_X_RDY  = 32'h5757_B57C;
    localparam logic [31:0] P_WTRM   = 32'h5858_B57C;
    localparam logic [31:0] P_HOLD   = 32'hD5D5_AA7C;
    localparam logic [31:0] P_HOLDA  = 32'h9595_AA7C;
    localparam logic [31:0] P_PREQ_S = 32'h7575_957C;
    localparam logic [31:0] P_PREQ_P = 32'h1717_B57C;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_CONT  = 2'd2;

    // Holds 0..JUNK_LIMIT+1; with no limit it only needs to saturate.
    localparam int RUN_W = $clog2(JUNK_LIMIT + 2);

    function automatic logic rep_prim(input logic [31:0] d);
        logic r;
        case (d)
            P_SYNC, P_R_RDY, P_R_IP, P_R_ERR, P_R_OK,
            P_X_RDY, P_WTRM, P_HOLD, P_HOLDA,
            P_PREQ_S, P_PREQ_P: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]       st_q, st_d;
    logic [31:0]      held_q, held_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [31:0]      dout_d;
    logic [3:0]       isk_d;
    logic             err_d;
    logic             act_d;
    logic             junk_inc;
    logic             cont_inc;

    logic is_k, is_align, is_cont, is_rep, over;

    assign is_k     = rx_is_k[0];
    assign is_align = is_k && (rx_din == P_ALIGN);
    assign is_cont  = is_k && (rx_din == P_CONT);
    assign is_rep   = is_k && rep_prim(rx_din);
    assign run_inc  = (&run_q) ? run_q : run_q + 1'b1;
    // Next junk dword would push the run past the limit.
    assign over     = (JUNK_LIMIT != 0) &&
                      (run_q >= RUN_W'(JUNK_LIMIT));

    always_comb begin
        st_d     = st_q;
        held_d   = held_q;
        run_d    = run_q;
        dout_d   = rx_din;
        isk_d    = rx_is_k;
        err_d    = 1'b0;
        junk_inc = 1'b0;
        cont_inc = 1'b0;
        if (!phy_ready) begin
            st_d   = ST_IDLE;
            dout_d = '0;
            isk_d  = '0;
        end else if (!is_align) begin
            unique case (st_q)
                ST_IDLE: begin
                    if (is_rep) begin
                        st_d   = ST_ARMED;
                        held_d = rx_din;
                    end else if (is_cont) begin
                        err_d = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (is_rep) begin
                        held_d = rx_din;
                    end else if (is_cont) begin
                        st_d     = ST_CONT;
                        dout_d   = held_q;
                        isk_d    = 4'b0001;
                        run_d    = '0;
                        cont_inc = 1'b1;
                    end else begin
                        st_d = ST_IDLE;
                    end
                end
                ST_CONT: begin
                    unique case (1'b1)
                        !is_k: begin
                            if (over) begin
                                err_d = 1'b1;
                                st_d  = ST_IDLE;
                            end else begin
                                dout_d   = held_q;
                                isk_d    = 4'b0001;
                                run_d    = run_inc;
                                junk_inc = 1'b1;
                            end
                        end
                        is_cont: begin
                            dout_d = held_q;
                            isk_d  = 4'b0001;
                        end
                        is_rep: begin
                            st_d   = ST_ARMED;
                            held_d = rx_din;
                        end
                        default: st_d = ST_IDLE;
                    endcase
                end
                default: st_d = ST_IDLE;
            endcase
        end
        act_d = (st_d == ST_CONT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= ST_IDLE;
            held_q      <= '0;
            run_q       <= '0;
            exp_dout    <= '0;
            exp_is_k    <= '0;
            exp_valid   <= 1'b0;
            cont_active <= 1'b0;
            cont_err    <= 1'b0;
        end else begin
            st_q        <= st_d;
            held_q      <= held_d;
            run_q       <= run_d;
            exp_dout    <= dout_d;
            exp_is_k    <= isk_d;
            exp_valid   <= phy_ready;
            cont_active <= act_d;
            cont_err    <= err_d;
        end
    end

    assign held_prim = held_q;

`ifdef CONT_RX_STATS_EN
    logic [CNT_W-1:0] junk_q, cont_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            junk_q <= '0;
            cont_q <= '0;
        end else begin
            if (junk_inc && !(&junk_q))
                junk_q <= junk_q + 1'b1;
            if (cont_inc && !(&cont_q))
                cont_q <= cont_q + 1'b1;
        end
    end

    assign junk_count = junk_q;
    assign cont_count = cont_q;
`else
    logic stats_unused;
    assign stats_unused = junk_inc ^ cont_inc;
    assign junk_count   = '0;
    assign cont_count   = '0;
`endif

endmodule

// File: tb/tb_cont_rx_expander.sv
// tb_cont_rx_expander: scoreboard bench for cont_rx_expander.
// Runs an unlimited instance and a JUNK_LIMIT=3, CNT_W=2 instance.
module tb_cont_rx_expander;

    localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] CONT  = 32'h9999_AA7C;
    localparam logic [31:0] SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] R_RDY = 32'h4A4A_957C;
    localparam logic [31:0] X_RDY = 32'h5757_B57C;
    localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] SOF   = 32'h3737_B57C;
    localparam logic [3:0]  K1    = 4'b0001;
    localparam logic [3:0]  K0    = 4'b0000;

    typedef struct {
        bit          sel;
        logic [31:0] d;
        logic [3:0]  k;
        logic        v;
        logic        a;
        logic        e;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    string test_name;
    int    checks = 0;
    int    errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        m_phy = 1'b1;
    logic [31:0] m_din = '0;
    logic [3:0]  m_k   = '0;
    logic [31:0] m_dout, m_held;
    logic [3:0]  m_isk;
    logic        m_v, m_act, m_err;
    logic [15:0] m_junk, m_cont;

    logic        l_phy = 1'b1;
    logic [31:0] l_din = '0;
    logic [3:0]  l_k   = '0;
    logic [31:0] l_dout, l_held;
    logic [3:0]  l_isk;
    logic        l_v, l_act, l_err;
    logic [1:0]  l_junk, l_cont;

    always #5 clk = ~clk;

    cont_rx_expander u_dut (
        .clk(clk), .rst(rst), .phy_ready(m_phy),
        .rx_din(m_din), .rx_is_k(m_k),
        .exp_dout(m_dout), .exp_is_k(m_isk),
        .exp_valid(m_v), .cont_active(m_act),
        .held_prim(m_held), .cont_err(m_err),
        .junk_count(m_junk), .cont_count(m_cont)
    );

    cont_rx_expander #(.JUNK_LIMIT(3), .CNT_W(2)) u_lim (
        .clk(clk), .rst(rst), .phy_ready(l_phy),
        .rx_din(l_din), .rx_is_k(l_k),
        .exp_dout(l_dout), .exp_is_k(l_isk),
        .exp_valid(l_v), .cont_active(l_act),
        .held_prim(l_held), .cont_err(l_err),
        .junk_count(l_junk), .cont_count(l_cont)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s/%s got %h want %h",
                     test_name, tag, obs, exp);
        end
    endtask

    function automatic int st(input int v);
`ifdef CONT_RX_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic step(input bit sel, input logic pr,
                        input logic [31:0] d, input logic [3:0] k,
                        input logic [31:0] ed, input logic [3:0] ek,
                        input logic ev, input logic ea,
                        input logic ee);
        exp_t e;
        @(negedge clk);
        if (sel) begin
            l_phy = pr; l_din = d; l_k = k;
        end else begin
            m_phy = pr; m_din = d; m_k = k;
        end
        e.sel = sel; e.d = ed; e.k = ek;
        e.v = ev; e.a = ea; e.e = ee;
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.sel) begin
                check("dout", l_dout, mon_e.d);
                check("isk", 32'(l_isk), 32'(mon_e.k));
                check("valid", 32'(l_v), 32'(mon_e.v));
                check("active", 32'(l_act), 32'(mon_e.a));
                check("err", 32'(l_err), 32'(mon_e.e));
            end else begin
                check("dout", m_dout, mon_e.d);
                check("isk", 32'(m_isk), 32'(mon_e.k));
                check("valid", 32'(m_v), 32'(mon_e.v));
                check("active", 32'(m_act), 32'(mon_e.a));
                check("err", 32'(m_err), 32'(mon_e.e));
            end
        end
    end

    task automatic check_reset();
        check("r_dout", m_dout, 0);
        check("r_isk", 32'(m_isk), 0);
        check("r_valid", 32'(m_v), 0);
        check("r_act", 32'(m_act), 0);
        check("r_err", 32'(m_err), 0);
        check("r_held", m_held, 0);
        check("r_junk", 32'(m_junk), 0);
        check("r_cont", 32'(m_cont), 0);
        check("r_ldout", l_dout, 0);
        check("r_lheld", l_held, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] j;
        test_name = "reset";
        #12;
        check_reset();
        @(negedge clk);
        rst = 1'b1;

        test_name = "orphan";
        step(0, 1, CONT, K1, CONT, K1, 1, 0, 1);
        step(0, 1, 32'h1234_5678, K0, 32'h1234_5678, K0, 1, 0, 0);

        test_name = "expand";
        step(0, 1, X_RDY, K1, X_RDY, K1, 1, 0, 0);
        step(0, 1, X_RDY, K1, X_RDY, K1, 1, 0, 0);
        step(0, 1, CONT, K1, X_RDY, K1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            j = $urandom;
            step(0, 1, j, K0, X_RDY, K1, 1, 1, 0);
        end
        step(0, 1, SOF, K1, SOF, K1, 1, 0, 0);
        settle();
        check("junk", 32'(m_junk), st(5));
        check("cont", 32'(m_cont), st(1));
        check("held", m_held, X_RDY);

        test_name = "align";
        step(0, 1, HOLD, K1, HOLD, K1, 1, 0, 0);
        step(0, 1, CONT, K1, HOLD, K1, 1, 1, 0);
        step(0, 1, 32'h0BAD_F00D, K0, HOLD, K1, 1, 1, 0);
        step(0, 1, ALIGN, K1, ALIGN, K1, 1, 1, 0);
        step(0, 1, ALIGN, K1, ALIGN, K1, 1, 1, 0);
        step(0, 1, 32'h5A5A_A5A5, K0, HOLD, K1, 1, 1, 0);

        test_name = "switch";
        step(0, 1, SYNC, K1, SYNC, K1, 1, 0, 0);
        step(0, 1, CONT, K1, SYNC, K1, 1, 1, 0);
        step(0, 1, 32'h1111_2222, K0, SYNC, K1, 1, 1, 0);
        step(0, 1, R_RDY, K1, R_RDY, K1, 1, 0, 0);
        step(0, 1, CONT, K1, R_RDY, K1, 1, 1, 0);
        step(0, 1, 32'h3333_4444, K0, R_RDY, K1, 1, 1, 0);
        settle();
        check("held", m_held, R_RDY);
        check("junk", 32'(m_junk), st(9));
        check("cont", 32'(m_cont), st(4));

        test_name = "phydrop";
        step(0, 1, 32'h7777_8888, K0, R_RDY, K1, 1, 1, 0);
        step(0, 0, 32'h9999_0000, K0, 0, K0, 0, 0, 0);
        step(0, 1, 32'hCAFE_F00D, 4'b1110,
             32'hCAFE_F00D, 4'b1110, 1, 0, 0);
        settle();
        check("held", m_held, R_RDY);
        check("junk", 32'(m_junk), st(10));

        test_name = "midreset";
        step(0, 1, SYNC, K1, SYNC, K1, 1, 0, 0);
        step(0, 1, CONT, K1, SYNC, K1, 1, 1, 0);
        step(0, 1, 32'hABCD_0123, K0, SYNC, K1, 1, 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, CONT, K1, CONT, K1, 1, 0, 1);

        test_name = "limit";
        step(1, 1, SYNC, K1, SYNC, K1, 1, 0, 0);
        step(1, 1, CONT, K1, SYNC, K1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            j = $urandom;
            step(1, 1, j, K0, SYNC, K1, 1, 1, 0);
        end
        step(1, 1, 32'hDEAD_BEEF, K0, 32'hDEAD_BEEF, K0, 1, 0, 1);
        step(1, 1, CONT, K1, CONT, K1, 1, 0, 1);
        settle();
        check("ljunk", 32'(l_junk), st(3));
        check("lcont", 32'(l_cont), st(1));

        test_name = "saturate";
        for (int i = 0; i < 3; i++) begin
            step(1, 1, SYNC, K1, SYNC, K1, 1, 0, 0);
            step(1, 1, CONT, K1, SYNC, K1, 1, 1, 0);
            step(1, 1, 32'h0F0F_0F0F, K0, SYNC, K1, 1, 1, 0);
        end
        settle();
        check("ljunk", 32'(l_junk), st(3));
        check("lcont", 32'(l_cont), st(3));
        check("lheld", l_held, SYNC);

        test_name = "flush";
        repeat (3) @(posedge clk);
        #2;
        check("queue", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cont_rx_expander.md
Name: cont_rx_expander

Overview:
Receive-side counterpart of link-layer CONT generation. It sits between the PHY receive stream and the link-layer primitive detectors. It undoes CONT compression: after a repeatable primitive followed by CONT, every scrambled junk dword and CONT is replaced with the held primitive until a new primitive arrives. Downstream logic therefore sees a plain repeated-primitive stream, with no CONT-specific detect terms.

Parameters:
JUNK_LIMIT, 0, max consecutive suppressed non-K dwords in one CONT run; 0 = unlimited
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  link clock
rst  in  1  reset; asynchronous, active-low (block in reset while rst==0)
phy_ready  in  1  PHY link up; when low, stream is ignored and state clears
rx_din  in  32  received dword
rx_is_k  in  4  K flags; only bit 0 is evaluated (primitive indicator)
exp_dout  out  32  expanded dword
exp_is_k  out  4  expanded K flags (4'b0001 for a substituted primitive)
exp_valid  out  1  exp_dout/exp_is_k valid this cycle
cont_active  out  1  currently inside a CONT run
held_prim  out  32  last repeatable primitive latched
cont_err  out  1  one-cycle pulse: CONT with no held primitive, or JUNK_LIMIT exceeded
junk_count  out  CNT_W  saturating count of suppressed junk dwords (see Optional Feature)
cont_count  out  CNT_W  saturating count of CONT runs entered (see Optional Feature)

Behaviour:
- Reset (rst==0, async): all outputs 0, state IDLE, held_prim 0, run counter 0.
- Latency: every output is registered; 1 clk from input dword to exp_dout. exp_valid = registered phy_ready.
- K dword = rx_is_k[0]==1. Primitive values come from sata_defines.v.
- Repeatable set: SYNC, R_RDY, R_IP, R_ERR, R_OK, X_RDY, WTRM, HOLD, HOLDA, PREQ_S, PREQ_P.
- ALIGN: passed through unchanged in every state. It never changes state, held_prim or the run counter.
- States: IDLE, ARMED, CONT_ACTIVE.
- IDLE:
  - repeatable K -> ARMED, latch held_prim, pass through.
  - CONT -> stay IDLE, output CONT unchanged, pulse cont_err.
  - anything else -> pass through.
- ARMED:
  - repeatable K -> relatch held_prim, pass through.
  - CONT -> CONT_ACTIVE, output held_prim with is_k=4'b0001, clear run counter, increment cont_count.
  - non-repeatable K (SOF, EOF, ...) or data -> IDLE, pass through.
- CONT_ACTIVE:
  - non-K -> output held_prim with K=4'b0001, run counter+1, junk_count+1.
  - CONT -> output held_prim, stay.
  - repeatable K -> ARMED, latch new held_prim, pass through.
  - other non-ALIGN K -> IDLE, pass through.
- cont_active=1 exactly while in CONT_ACTIVE (registered with the output).
- JUNK_LIMIT!=0: on the dword that makes the run counter exceed JUNK_LIMIT, pulse cont_err, go to IDLE, and pass that dword through unchanged.
- phy_ready low: state to IDLE, held_prim kept, exp_valid=0, exp_dout=0. No cont_err.
- Counters saturate at all-ones and never wrap.

Optional Feature:
CONT_RX_STATS_EN:
- Defined: junk_count and cont_count operate as described.
- Undefined: both ports are tied to 0, and the counter registers are not built.
- All other behaviour is identical in both builds.

Test Plan:
- Expansion: input X_RDY 0x5757B57C (K) x2, CONT 0x9999AA7C (K), 5 random non-K dwords, SOF 0x3737B57C (K) -> output 1 clk later is X_RDY x8 (all is_k=0001) then SOF. cont_active=1 for 6 cycles. junk_count=5, cont_count=1.
- ALIGN in run: HOLD 0xD5D5AA7C, CONT, junk, ALIGN 0x7B4A4ABC x2, junk -> output HOLD, HOLD, HOLD, ALIGN, ALIGN, HOLD. State remains CONT_ACTIVE throughout.
- Orphan CONT: after reset, input CONT -> output CONT, cont_err pulses 1 cycle, cont_active=0.
- Limit: JUNK_LIMIT=3; input SYNC 0xB5B5957C, CONT, 4 junk -> 3 substituted SYNCs. The 4th junk dword passes through raw with cont_err=1, state IDLE.
- Primitive switch: SYNC, CONT, junk, R_RDY, CONT, junk -> SYNC x3, R_RDY x3. held_prim ends at R_RDY, cont_count=2.
- Reset/phy drop: during CONT_ACTIVE, drive rst=0 mid-cycle -> all outputs 0 immediately. Separately, drop phy_ready during CONT_ACTIVE -> exp_valid=0 next clk; the following junk dword passes raw (state IDLE).
